// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the memory port served by mem_port_arbiter.
// The slave modport is the arbiter's view; master is the pipeline/memory side.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  // Instruction-fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_kill;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  // Load/store port
  logic                d_req;
  logic                d_we;
  logic [DATA_W/8-1:0] d_be;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic                d_gnt;
  logic                d_rvalid;
  logic [DATA_W-1:0]   d_rdata;

  // Memory port
  logic                mem_req;
  logic                mem_we;
  logic [DATA_W/8-1:0] mem_be;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_rvalid;
  logic [DATA_W-1:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr, if_kill,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rvalid, mem_rdata
  );

  modport master (
    output if_req, if_addr, if_kill,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported data memory between fetch and load/store with one outstanding
// transaction; data normally wins, a starvation counter forces fetch through.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output logic                busy
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  typedef enum logic {StIdle, StWait} state_e;
  typedef enum logic {OwnFetch, OwnData} owner_e;

  state_e          state_q;
  owner_e          owner_q;
  logic            killed_q;
  logic [CntW-1:0] starve_cnt_q;
  logic            busy_q;

  logic fetch_ok, fetch_force, in_idle, grant_f, grant_d, resp, if_rvalid, d_rvalid;

  // Every output is forced low while reset is asserted, so gate on it here.
  assign in_idle     = (state_q == StIdle) && !reset;
  assign fetch_ok    = bus.if_req && !bus.if_kill;
  assign fetch_force = fetch_ok && (starve_cnt_q == CntMax);
  assign grant_f     = in_idle && fetch_ok && (fetch_force || !bus.d_req);
  assign grant_d     = in_idle && bus.d_req && !fetch_force;

  assign resp      = (state_q == StWait) && bus.mem_rvalid && !reset;
  assign d_rvalid  = resp && (owner_q == OwnData);
  assign if_rvalid = resp && (owner_q == OwnFetch) && !killed_q && !bus.if_kill;

  assign bus.if_gnt    = grant_f;
  assign bus.d_gnt     = grant_d;
  assign bus.mem_req   = grant_f || grant_d;
  assign bus.if_rvalid = if_rvalid;
  assign bus.d_rvalid  = d_rvalid;
  assign bus.if_rdata  = if_rvalid ? bus.mem_rdata : '0;
  assign bus.d_rdata   = d_rvalid ? bus.mem_rdata : '0;
  assign busy          = busy_q && !reset;

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_be    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (grant_f) begin
      bus.mem_be   = '1;
      bus.mem_addr = bus.if_addr;
    end else if (grant_d) begin
      bus.mem_we    = bus.d_we;
      bus.mem_be    = bus.d_be;
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= OwnFetch;
      killed_q     <= 1'b0;
      starve_cnt_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_f || grant_d) begin
            state_q  <= StWait;
            busy_q   <= 1'b1;
            killed_q <= 1'b0;
            owner_q  <= grant_f ? OwnFetch : OwnData;
          end
          // Count only cycles where a live fetch lost to data.
          if (grant_d && fetch_ok) begin
            if (starve_cnt_q != CntMax) starve_cnt_q <= starve_cnt_q + 1'b1;
          end else begin
            starve_cnt_q <= '0;
          end
        end
        StWait: begin
          if (bus.if_kill && (owner_q == OwnFetch)) killed_q <= 1'b1;
          if (bus.mem_rvalid) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus queues expected grant/response events and a
// negedge monitor pops and compares them whenever the arbiter shows a grant or response.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  logic busy;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [41:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Observation layout: {if_gnt, d_gnt, if_rvalid, d_rvalid, mem_req, mem_we, mem_be, value}
  function automatic logic [41:0] mk(logic [3:0] ev, logic req, logic we, logic [3:0] be,
                                     logic [31:0] v);
    return {ev, req, we, be, v};
  endfunction

  function automatic logic [41:0] gf(logic [31:0] a);
    return mk(4'b1000, 1'b1, 1'b0, 4'hF, a);
  endfunction

  function automatic logic [41:0] gd(logic [31:0] a, logic we, logic [3:0] be);
    return mk(4'b0100, 1'b1, we, be, a);
  endfunction

  function automatic logic [41:0] rf(logic [31:0] d);
    return mk(4'b0010, 1'b0, 1'b0, 4'h0, d);
  endfunction

  function automatic logic [41:0] rd(logic [31:0] d);
    return mk(4'b0001, 1'b0, 1'b0, 4'h0, d);
  endfunction

  task automatic push(input string name, input logic [41:0] v);
    exp_t e;
    e.name = name;
    e.v    = v;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Both rdata buses are ORed so a leak onto the idle one shows up as wrong data.
  always @(negedge clk) begin
    logic [3:0]  ev;
    logic [31:0] val;
    logic [41:0] obs;
    exp_t        e;
    ev  = {bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid};
    val = bus.mem_req ? bus.mem_addr : (bus.if_rdata | bus.d_rdata);
    obs = {ev, bus.mem_req, bus.mem_we, bus.mem_be, val};
    if (ev != 4'b0 || bus.mem_req) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got %h expected none", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
        end
      end
    end
  end

  initial begin
    logic [9:0] fetch_pat;
    fetch_pat = 10'b10000_10000;  // bit i set => fetch wins transaction i

    bus.if_req = 1'b1; bus.if_addr = 32'h100; bus.if_kill = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'h0; bus.d_addr = 32'h200;
    bus.d_wdata = 32'h0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    reset = 1'b1;

    // Reset with both requests high: nothing granted.
    step();
    @(negedge clk);
    chk("reset_outputs", {58'h0, bus.if_gnt, bus.d_gnt, bus.mem_req, bus.if_rvalid,
                          bus.d_rvalid, busy}, 64'h0);

    step(); reset = 1'b0; push("first_d_grant", gd(32'h200, 1'b0, 4'h0));
    step(); bus.if_req = 1'b0; bus.d_req = 1'b0;
    @(negedge clk); chk("busy_after_grant", {63'h0, busy}, 64'h1);
    step(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1111_1111;
    push("first_d_resp", rd(32'h1111_1111));

    // Fetch 0x100 with two-cycle memory latency.
    step(); bus.mem_rvalid = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h100;
    push("fetch_grant", gf(32'h100));
    @(negedge clk); chk("busy_idle", {63'h0, busy}, 64'h0);
    step(); bus.if_req = 1'b0;
    // Store request raised in the response cycle must wait for the bubble.
    step(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    push("fetch_resp", rf(32'hDEAD_BEEF));
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0011; bus.d_addr = 32'h300;
    bus.d_wdata = 32'h1234;
    step(); bus.mem_rvalid = 1'b0; push("store_grant", gd(32'h300, 1'b1, 4'b0011));
    @(negedge clk); chk("store_wdata", {32'h0, bus.mem_wdata}, 64'h1234);
    step(); bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0; bus.d_wdata = 32'h0;
    step(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h55; push("store_ack", rd(32'h55));
    step(); bus.mem_rvalid = 1'b0;

    // Both ports held high, memory latency 1: D,D,D,D,F,D,D,D,D,F.
    bus.if_req = 1'b1; bus.if_addr = 32'h400; bus.d_req = 1'b1; bus.d_addr = 32'h500;
    for (int i = 0; i < 10; i++) begin
      push("starve_grant", fetch_pat[i] ? gf(32'h400) : gd(32'h500, 1'b0, 4'h0));
      step(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hA0 + i;
      push("starve_resp", fetch_pat[i] ? rf(32'hA0 + i) : rd(32'hA0 + i));
      step(); bus.mem_rvalid = 1'b0;
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;

    // Kill pulsed in WAIT drops the response; next fetch completes.
    step(); bus.if_req = 1'b1; bus.if_addr = 32'h600; push("kill_fetch_grant", gf(32'h600));
    step(); bus.if_req = 1'b0; bus.if_kill = 1'b1;
    step(); bus.if_kill = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD0;
    @(negedge clk); chk("killed_no_rvalid", {63'h0, bus.if_rvalid}, 64'h0);
    step(); bus.mem_rvalid = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h700;
    push("refetch_grant", gf(32'h700));
    step(); bus.if_req = 1'b0;
    step(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h7777; push("refetch_resp", rf(32'h7777));

    // Kill in the grant cycle with no data request: nothing issued.
    step(); bus.mem_rvalid = 1'b0; bus.if_req = 1'b1; bus.if_kill = 1'b1;
    @(negedge clk); chk("kill_in_grant", {62'h0, bus.if_gnt, bus.mem_req}, 64'h0);

    // Kill coincident with the response also drops it.
    step(); bus.if_kill = 1'b0; bus.if_addr = 32'h800; push("late_kill_grant", gf(32'h800));
    step(); bus.if_req = 1'b0;
    step(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h8888; bus.if_kill = 1'b1;
    @(negedge clk); chk("kill_at_resp", {63'h0, bus.if_rvalid}, 64'h0);
    step(); bus.mem_rvalid = 1'b0; bus.if_kill = 1'b0;

    // Reset mid-WAIT abandons the transaction; the late response is ignored.
    bus.d_req = 1'b1; bus.d_addr = 32'h900; push("pre_reset_grant", gd(32'h900, 1'b0, 4'h0));
    step(); bus.d_req = 1'b0;
    step(); reset = 1'b1;
    @(negedge clk); chk("reset_in_wait", {62'h0, busy, bus.d_rvalid}, 64'h0);
    step(); reset = 1'b0;
    step(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h999; bus.d_req = 1'b1;
    bus.d_addr = 32'hA00; push("post_reset_grant", gd(32'hA00, 1'b0, 4'h0));
    step(); bus.mem_rvalid = 1'b0; bus.d_req = 1'b0;
    step(); bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hABAB; push("post_reset_resp", rd(32'hABAB));
    step(); bus.mem_rvalid = 1'b0;
    step();
    @(negedge clk); chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported data memory between the instruction-fetch port and the load/store (MEM-stage) port of the pipeline. It accepts at most one outstanding transaction, returns each response only to the requester that issued it, and drops fetch responses killed by a pipeline flush. Data accesses normally win arbitration; a starvation counter guarantees fetch progress.

## Interface
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- STARVE_LIMIT, 4, consecutive lost fetch arbitrations before fetch is forced to win; must be ≥1

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, no other clock domains
- if_req  in  1  fetch request valid
- if_addr  in  ADDR_W  fetch address
- if_kill  in  1  pipeline flush; masks if_req this cycle, cancels in-flight fetch response
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch response valid
- if_rdata  out  DATA_W  fetch response data
- d_req  in  1  data request valid
- d_we  in  1  1 = store, 0 = load
- d_be  in  DATA_W/8  store byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data response valid (load data, or store acknowledge)
- d_rdata  out  DATA_W  load data
- mem_req  out  1  memory request strobe
- mem_we, mem_be, mem_addr, mem_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  memory request fields
- mem_rvalid  in  1  memory response/acknowledge (loads and stores)
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  transaction outstanding

## Operation
- FSM states: IDLE, WAIT. Registers: owner (FETCH/DATA), killed flag, starve_cnt of width clog2(STARVE_LIMIT+1).
- IDLE: eligible fetch = if_req && !if_kill. Priority:
  - If starve_cnt == STARVE_LIMIT and eligible fetch is present, fetch wins.
  - Otherwise d_req wins; else eligible fetch wins.
- On grant: assert the winner's gnt and mem_req in the same cycle. Drive the mem_* fields from the winner; fetch drives we=0, be=all-ones, wdata=0. Latch owner, clear killed, go to WAIT.
- With no request, mem_req=0 and mem_* fields are 0.
- starve_cnt:
  - Cleared on any fetch grant, and on any IDLE cycle without an eligible fetch.
  - Incremented (saturating at STARVE_LIMIT) on an IDLE cycle where an eligible fetch loses to data.
  - Held in WAIT.
- WAIT: no grants; gnt=0, mem_req=0, busy=1.
  - if_kill while owner=FETCH sets killed.
  - On mem_rvalid: if owner=DATA, d_rvalid=1 and d_rdata=mem_rdata. If owner=FETCH and !killed and !if_kill (same cycle), if_rvalid=1 and if_rdata=mem_rdata; otherwise the response is dropped silently. Return to IDLE.
- mem_rvalid in IDLE is a stray response (e.g. after reset). It is ignored and produces no rvalid.
- rdata outputs are 0 whenever the corresponding rvalid is 0.
- Requesters hold req/addr/data stable until gnt; the arbiter does not buffer requests.

## Timing
- Reset: state=IDLE, owner=FETCH, killed=0, starve_cnt=0. All outputs 0 during the reset cycle, including gnt even if req is high.
- Grant is combinational from IDLE state plus req inputs: zero-cycle acceptance.
- Response latency equals memory latency. rvalid is a same-cycle pass-through of mem_rvalid, gated by owner/killed.
- Back-to-back throughput: one transaction per (memory latency + 1) cycles. The cycle after mem_rvalid is always IDLE (one-cycle bubble, no grant in the response cycle).
- busy = (state == WAIT), registered.
- Reset mid-WAIT: the transaction is abandoned. The late mem_rvalid arrives in IDLE and is ignored.
- if_kill in the grant cycle with d_req=0: no fetch grant, mem_req=0.

## Test plan
- Reset with if_req=d_req=1 → both gnt=0, mem_req=0. First post-reset cycle → d_gnt=1, mem_addr=d_addr, busy=1 next cycle.
- Fetch 0x100, memory returns 0xDEADBEEF 2 cycles later → if_rvalid=1, if_rdata=0xDEADBEEF in that cycle, d_rvalid=0. IDLE next cycle.
- Store d_we=1, d_be=4'b0011, wdata 0x1234 → mem_we=1, mem_be=0011. mem_rvalid → d_rvalid=1.
- if_req and d_req held high continuously, STARVE_LIMIT=4 → grant sequence D,D,D,D,F,D,D,D,D,F,…
- Fetch granted, if_kill pulsed in WAIT, then mem_rvalid → if_rvalid stays 0. A fetch issued next IDLE cycle completes normally.
- Reset asserted mid-WAIT, mem_rvalid arrives 1 cycle after reset deasserts → no rvalid on either port; a new d_req is granted in the same cycle.
